// File: rtl/dot_product_serial.sv
// Bit-serial dot product: result = popcount(vec_a & vec_b), BPC bits per cycle.
// Define DOT_PRODUCT_EARLY_EXIT_EN to finish as soon as the remaining bits are all zero.
module dot_product_serial #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1,
  parameter int RES_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] vec_a,
  input  logic [WIDTH-1:0] vec_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] result,
  output logic             busy
);
  localparam int BEATS = WIDTH / BPC;
  localparam int CW    = $clog2(BEATS + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg, sh_nxt;
  logic [CW-1:0]    cnt;
  logic [RES_W-1:0] acc, acc_nxt;
  logic             last;

  function automatic logic [RES_W-1:0] slice_pop(input logic [BPC-1:0] s);
    logic [RES_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < BPC; i++) sum = sum + RES_W'(s[i]);
    return sum;
  endfunction

  always_comb begin
    acc_nxt = acc + slice_pop(shreg[BPC-1:0]);
    sh_nxt  = shreg >> BPC;
  end

`ifdef DOT_PRODUCT_EARLY_EXIT_EN
  // Nothing left to count once the post-shift remainder is zero.
  assign last = (cnt == CW'(1)) || (sh_nxt == '0);
`else
  assign last = (cnt == CW'(1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      shreg     <= '0;
      cnt       <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          shreg    <= vec_a & vec_b;
          acc      <= '0;
          cnt      <= CW'(BEATS);
          in_ready <= 1'b0;
          busy     <= 1'b1;
          state    <= BUSY;
        end
        BUSY: begin
          acc   <= acc_nxt;
          shreg <= sh_nxt;
          cnt   <= cnt - CW'(1);
          if (last) begin
            busy      <= 1'b0;
            out_valid <= 1'b1;
            result    <= acc_nxt;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          // in_ready rises only now, so a new accept can't overlap the result handshake.
          out_valid <= 1'b0;
          result    <= '0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dot_product_serial.md
Name: dot_product_serial

Overview:
- Sequential counterpart of the combinational bit-vector dot product used in the datapath.
- Accepts a pair of WIDTH-bit vectors over a valid/ready handshake.
- Computes result = popcount(vec_a & vec_b) by shifting BPC bits per cycle, then holds the result on a valid/ready output until it is consumed.
- Sits between an operand source, such as a register-file read or a test driver, and a result sink; it trades area for latency.

Parameters:
- WIDTH, 32: vector width in bits.
- BPC, 1: bits processed per cycle. WIDTH must be an exact multiple of BPC; legal values are 1, 2, 4, 8, 16, 32.
- RES_W, 6: result width. Must equal clog2(WIDTH+1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair present on vec_a/vec_b.
- in_ready  output  1  block can accept an operand pair.
- vec_a  input  WIDTH  operand A.
- vec_b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts the result.
- result  output  RES_W  popcount(vec_a & vec_b), range 0..WIDTH.
- busy  output  1  high while in BUSY.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values:
  - in_ready=1, out_valid=0, busy=0, result=0.
  - Internal shift register=0, beat counter=0, accumulator=0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch m = vec_a & vec_b into the shift register, clear the accumulator, set the beat counter to WIDTH/BPC, go to BUSY.
  - Operands are sampled only at that accept edge. Later changes on vec_a/vec_b are ignored.
- BUSY:
  - in_ready=0, busy=1.
  - Each edge: accumulator += popcount(low BPC bits of the shift register); shift register >>= BPC; counter -= 1.
  - When the counter reaches 1 in this edge (the last beat), go to DONE.
- Latency: accept at edge k → out_valid=1 after edge k+WIDTH/BPC. With defaults, that is 32 cycles.
- DONE:
  - out_valid=1; result = accumulator, held stable; in_ready=0.
  - On out_valid&&out_ready at an edge: out_valid drops and the FSM returns to IDLE.
  - in_ready rises in the cycle after the result handshake.
  - No same-cycle accept of a new operand while in DONE: this gives a one-cycle bubble, and the result is held unchanged while waiting.
- Backpressure: out_ready low holds DONE indefinitely. result and out_valid must not change.
- in_valid high while in BUSY or DONE: ignored, no accept. The source must hold its data until in_ready.
- Arithmetic:
  - The accumulator is RES_W bits and can never overflow (maximum WIDTH).
  - popcount of a BPC-bit slice is zero-extended to RES_W.
- Boundary values: all-zero operands give result=0; all-ones gives result=WIDTH (32 = 6'b100000).
- Reset mid-operation (BUSY or DONE): return to IDLE at that edge with all reset values. The pending computation is discarded and no out_valid is produced.
- result reads 0 in IDLE and BUSY. It is meaningful only while out_valid=1.

Optional Feature:
- Macro: DOT_PRODUCT_EARLY_EXIT_EN.
- Defined:
  - In BUSY, if the value that the shift register will hold after this edge's shift is zero, go to DONE at this edge with the final accumulator value.
  - Accept with m==0 → DONE after edge k+1.
  - In general, latency = ceil((index of highest set bit of m + 1)/BPC), minimum 1. Example with BPC=1: a=3, b=6 gives m=2 and DONE after edge k+2.
  - result is identical to the non-early-exit case.
- Not defined: fixed latency of WIDTH/BPC cycles for every operand pair.

Test Plan:
- Basic values, defaults:
  - a=3, b=6 → result=1.
  - a=13, b=15 → 3.
  - a=33, b=31 → 1.
  - a=14, b=15 → 3.
  - Each case has out_valid exactly 32 cycles after accept, and busy high for those 32 cycles.
- Extremes: a=b=32'hFFFFFFFF → result=32. a=0, b=32'hFFFFFFFF → result=0.
- Backpressure: out_ready held 0 for 10 cycles after out_valid → result, out_valid and in_ready=0 all stable. in_valid toggled during this time causes no accept. out_ready=1 → IDLE, and in_ready=1 on the next cycle.
- Reset mid-BUSY: assert reset for 1 cycle 5 cycles after accepting a=b=32'hFFFF → out_valid stays 0, in_ready=1 after reset. A new pair a=13, b=15 then gives 3.
- BPC=4 build: a=33, b=31 → result=1 after 8 cycles. BPC=32 build → result after 1 cycle.
- With DOT_PRODUCT_EARLY_EXIT_EN, BPC=1:
  - a=3, b=6 → result=1 after 2 cycles.
  - a=0, b=0 → result=0 after 1 cycle.
  - a=b=32'h80000000 → result=1 after 32 cycles.
